// File: rtl/data_memory_bist_if.sv
// Data memory port bundle: strobes, address and write data from the
// initiator, read data back from the memory.
interface data_memory_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              sel;
  logic              str;
  logic              ld;
  logic              clr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  // BIST side drives the port
  modport master (
    output sel, str, ld, clr, addr, wdata,
    input  rdata
  );

  // memory side
  modport slave (
    input  sel, str, ld, clr, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/data_memory_bist.sv
// Data memory BIST initiator: two-phase write/read-compare march over
// addresses 0..DEPTH-1, reporting pass/fail, first failing address/data
// and a saturating mismatch count.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | port quiet, status held, waiting for start
// WR_A  | write PATTERN ^ addr, one word per cycle
// RD_A  | present read address for phase A
// CMP_A | hold read, compare returned word against phase A data
// WR_B  | write ~(PATTERN ^ addr), one word per cycle
// RD_B  | present read address for phase B
// CMP_B | hold read, compare returned word against phase B data
// FIN   | run finished, done/pass valid, return to IDLE
module data_memory_bist #(
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 1024,
  parameter logic [DATA_W-1:0] PATTERN = 32'hA5A5_5A5A,
  parameter int                ERR_W   = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  data_memory_bist_if.master   mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR_A  = 3'd1;
  localparam logic [2:0] RD_A  = 3'd2;
  localparam logic [2:0] CMP_A = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;
  localparam logic [2:0] RD_B  = 3'd5;
  localparam logic [2:0] CMP_B = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              phase_b;
  logic              last_addr;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;
  logic              err_max;
  logic              err_none;

  // Expected word for the current phase and address
  always_comb begin
    phase_b   = (state == WR_B) || (state == RD_B) || (state == CMP_B);
    last_addr = (addr == LAST_ADDR);
    exp_data  = PATTERN ^ DATA_W'(addr);
    if (phase_b) begin
      exp_data = ~exp_data;
    end
    mismatch  = (mem.rdata != exp_data);
    err_max   = &err_count;
    err_none  = (err_count == '0);
  end

  // Memory port strobes decoded from state; quiet outside an active run
  always_comb begin
    mem.sel   = 1'b0;
    mem.str   = 1'b0;
    mem.ld    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    case (state)
      WR_A, WR_B: begin
        mem.sel   = 1'b1;
        mem.str   = 1'b1;
        mem.addr  = addr;
        mem.wdata = exp_data;
      end
      RD_A, CMP_A, RD_B, CMP_B: begin
        mem.sel  = 1'b1;
        mem.ld   = 1'b1;
        mem.addr = addr;
      end
      default: ;
    endcase
  end

  // The BIST never clears the memory
  assign mem.clr = 1'b0;

  // March sequencer, address counter and result capture
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            addr      <= '0;
            state     <= WR_A;
          end
        end
        WR_A, WR_B: begin
          if (last_addr) begin
            addr  <= '0;
            state <= (state == WR_A) ? RD_A : RD_B;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        RD_A: state <= CMP_A;
        RD_B: state <= CMP_B;
        CMP_A, CMP_B: begin
          // err_count==0 doubles as "no mismatch seen yet" since it never wraps
          if (mismatch) begin
            if (!err_max) begin
              err_count <= err_count + 1'b1;
            end
            if (err_none) begin
              fail_addr <= addr;
              fail_data <= mem.rdata;
            end
          end
          if (last_addr) begin
            addr <= '0;
            if (state == CMP_A) begin
              state <= WR_B;
            end else begin
              // status lands on the same edge busy falls, so the run is 6*DEPTH cycles
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= err_none && !mismatch;
            end
          end else begin
            addr  <= addr + 1'b1;
            state <= (state == CMP_A) ? RD_A : RD_B;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_bist.sv
// Bench for data_memory_bist: DEPTH=16 against a registered-read memory
// model with injectable stuck-at bits, plus an ERR_W=4 instance whose
// memory always reads zero.
module tb_data_memory_bist;
  localparam int          AW  = 10;
  localparam int          DW  = 32;
  localparam int          DEP = 16;
  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  logic clk;
  logic clr_n;
  logic start;

  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [15:0]   err_count;

  logic          busy4, done4, pass4;
  logic [AW-1:0] fail_addr4;
  logic [DW-1:0] fail_data4;
  logic [3:0]    err_count4;

  data_memory_bist_if #(.ADDR_W(AW), .DATA_W(DW)) m ();
  data_memory_bist_if #(.ADDR_W(AW), .DATA_W(DW)) m4 ();

  data_memory_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .PATTERN(PAT), .ERR_W(16)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .mem(m),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count)
  );

  data_memory_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .PATTERN(PAT), .ERR_W(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .start(start), .mem(m4),
    .busy(busy4), .done(done4), .pass(pass4),
    .fail_addr(fail_addr4), .fail_data(fail_data4), .err_count(err_count4)
  );

  assign m4.rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: registered read with per-word stuck-at masks
  logic [31:0] mem_arr [DEP];
  logic [31:0] and_m   [DEP];
  logic [31:0] or_m    [DEP];

  always @(posedge clk) begin
    if (m.sel && m.str) mem_arr[m.addr[3:0]] <= m.wdata;
    if (m.sel && m.ld)  m.rdata <= (mem_arr[m.addr[3:0]] & and_m[m.addr[3:0]]) | or_m[m.addr[3:0]];
  end

  // write log
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  always @(posedge clk) begin
    if (m.sel && m.str) begin
      wr_addr_q.push_back(m.addr);
      wr_data_q.push_back(m.wdata);
    end
  end

  // port rule violations
  int viol = 0;
  always @(negedge clk) begin
    if (m.str && m.ld) viol++;
    if (!busy && m.sel) viol++;
    if (m.clr || m4.clr) viol++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEP; i++) begin
      and_m[i] = '1;
      or_m[i]  = '0;
    end
  endtask

  // reference: walk both phases over the address range in plain arithmetic
  task automatic ref_run(output int e, output logic [AW-1:0] fa, output logic [DW-1:0] fd);
    logic [31:0] w, r;
    e = 0; fa = '0; fd = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < DEP; a++) begin
        w = PAT ^ 32'(a);
        if (ph == 1) w = ~w;
        r = (w & and_m[a]) | or_m[a];
        if (r != w) begin
          if (e == 0) begin
            fa = AW'(a);
            fd = r;
          end
          if (e < 65535) e++;
        end
      end
    end
  endtask

  task automatic do_run(input string name, input int mid_start);
    int            e_err, cyc, wbase;
    logic [AW-1:0] e_fa;
    logic [DW-1:0] e_fd;
    ref_run(e_err, e_fa, e_fd);
    wbase = wr_addr_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".accept_busy"}, 64'(busy), 64'd1);
    check({name, ".accept_done"}, 64'(done), 64'd0);
    check({name, ".accept_err"},  64'(err_count), 64'd0);
    check({name, ".accept_fail"}, {fail_addr, fail_data}, 64'd0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      start = (cyc == mid_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, ".busy_cycles"}, 64'(cyc), 64'(6 * DEP));
    check({name, ".n_writes"}, 64'(wr_addr_q.size() - wbase), 64'(2 * DEP));
    if (wr_addr_q.size() >= wbase + 1) begin
      check({name, ".first_wr"}, {wr_addr_q[wbase], wr_data_q[wbase]}, {10'd0, PAT});
      check({name, ".last_wr"},  {wr_addr_q[$], wr_data_q[$]}, {10'(DEP - 1), ~(PAT ^ 32'(DEP - 1))});
    end
    check({name, ".done"},      64'(done), 64'd1);
    check({name, ".pass"},      64'(pass), 64'(e_err == 0));
    check({name, ".err_count"}, 64'(err_count), 64'(e_err));
    check({name, ".fail_addr"}, 64'(fail_addr), 64'(e_fa));
    check({name, ".fail_data"}, 64'(fail_data), 64'(e_fd));
    @(negedge clk);
  endtask

  initial begin
    int na, aa, bb;
    clr_n = 1'b0;
    start = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    check("rst.busy_done_pass", {busy, done, pass}, 64'd0);
    check("rst.strobes", {m.sel, m.str, m.ld, m.clr}, 64'd0);
    check("rst.addr_wdata", {m.addr, m.wdata}, 64'd0);
    check("rst.status", {fail_addr, err_count}, 64'd0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    do_run("clean", -1);
    check("sat.err_count", 64'(err_count4), 64'd15);
    check("sat.pass_done", {pass4, done4}, 64'b01);
    check("sat.fail_addr", 64'(fail_addr4), 64'd0);
    check("sat.fail_data", 64'(fail_data4), 64'd0);

    and_m[5] = 32'hFFFF_FFFE;
    do_run("stuck5", -1);
    check("stuck5.fixed_err", 64'(err_count), 64'd1);
    check("stuck5.fixed_fa", 64'(fail_addr), 64'd5);
    check("stuck5.fixed_fd", 64'(fail_data), 64'hA5A5_5A5E);

    clear_faults();
    do_run("b2b", -1);
    check("b2b.fixed_pass", {pass, err_count}, {1'b1, 16'd0});

    do_run("mid_start", 10);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("abort.pre_rd", {m.ld, m.str, m.addr}, {2'b10, 10'd3});
    #1 clr_n = 1'b0;
    #1;
    check("abort.strobes", {m.sel, m.str, m.ld, m.clr}, 64'd0);
    check("abort.addr_wdata", {m.addr, m.wdata}, 64'd0);
    check("abort.flags", {busy, done, pass, busy4}, 64'd0);
    check("abort.status", {fail_addr, err_count}, 64'd0);
    check("abort.fail_data", 64'(fail_data), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    do_run("after_abort", -1);

    for (int k = 0; k < 4; k++) begin
      clear_faults();
      na = $urandom_range(0, 3);
      for (int i = 0; i < na; i++) begin
        aa = $urandom_range(0, DEP - 1);
        bb = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) or_m[aa][bb] = 1'b1;
        else and_m[aa][bb] = 1'b0;
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_run($sformatf("rnd%0d", k), -1);
    end

    check("port_rules", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_bist.md
Name: data_memory_bist

Overview:
- Built-in self-test initiator for the data memory: it is the master that drives the memory's sel/str/ld/addr/data_in strobes and checks its data_out.
- On start it runs a two-phase write/read-compare march over every word and reports pass/fail, the first failing address and data, and an error count.
- It sits beside the CPU datapath and owns the memory port while busy is high. External muxing of that port is outside this block.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 32, memory word width.
- DEPTH, 1024, number of words tested (addresses 0..DEPTH-1). DEPTH must be at most 2^ADDR_W.
- PATTERN, 32'hA5A5_5A5A, base data pattern.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a test. Ignored while busy.
- mem_sel  out  1  memory select.
- mem_str  out  1  memory store strobe.
- mem_ld  out  1  memory load strobe.
- mem_clr  out  1  memory clear. Tied 0; the BIST never clears memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  data to memory data_in.
- mem_rdata  in  DATA_W  data from memory data_out.
- busy  out  1  test in progress.
- done  out  1  sticky; set at test end, cleared by the next accepted start.
- pass  out  1  valid when done=1; 1 means no mismatches.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  read data at the first mismatch.
- err_count  out  ERR_W  mismatch count, saturating at all-ones.

Behaviour:
- Reset (asynchronous, immediate, also mid-test):
  - All outputs go to 0: mem_* strobes, mem_addr, mem_wdata, busy, done, pass, fail_addr, fail_data, err_count.
  - FSM goes to IDLE and the address counter goes to 0.
- Expected data:
  - Phase A: expA(a) = PATTERN ^ zero-extended a.
  - Phase B: expB(a) = ~expA(a).
- FSM states: IDLE, WR_A, RD_A, CMP_A, WR_B, RD_B, CMP_B, FIN.
- IDLE:
  - Memory strobes are low.
  - A start accepted here sets busy=1 on the next edge.
  - It also clears done, pass, err_count, fail_addr, fail_data, sets addr=0, and moves to WR_A.
- WR_x (one cycle per address):
  - Drive mem_sel=1, mem_str=1, mem_ld=0, mem_addr=addr, mem_wdata=expx(addr).
  - If addr == DEPTH-1: set addr=0 and go to RD_x. Otherwise increment addr.
- RD_x:
  - Drive mem_sel=1, mem_ld=1, mem_str=0, mem_addr=addr. Next state is CMP_x.
- CMP_x:
  - Hold mem_sel=1, mem_ld=1, mem_addr=addr.
  - Sample mem_rdata at the closing edge of this state, i.e. one cycle after the read address is presented. This tolerates a registered-read memory.
  - On mismatch with expx(addr): increment err_count, saturating. If this is the first mismatch of the run, capture fail_addr=addr and fail_data=mem_rdata.
  - If addr == DEPTH-1: set addr=0, then go to WR_B from CMP_A, or to FIN from CMP_B. Otherwise increment addr and return to RD_x.
- FIN:
  - Strobes low, busy=0, done=1, pass = (err_count == 0). Go to IDLE in the same cycle.
- Latency: exactly 6*DEPTH cycles from the start-accept edge to the busy-fall edge. Each read costs 2 cycles; each write costs 1.
- Strobe rules:
  - mem_str and mem_ld are never high together.
  - mem_sel=0 whenever busy=0.
  - mem_clr is always 0.
- Edge cases:
  - start while busy is ignored and has no effect.
  - start held high across FIN restarts immediately after IDLE.
  - err_count saturates at 2^ERR_W-1 and never wraps.
  - Status outputs hold their last values in IDLE until the next start.

Test Plan:
- Fault-free memory model, DEPTH=16, start pulse:
  - busy high for exactly 96 cycles.
  - First write is addr=0, wdata=32'hA5A55A5A.
  - Last WR_B write is addr=15, wdata=32'h5A5AA5AA.
  - At the end: done=1, pass=1, err_count=0.
- Model with bit 0 stuck-at-0 at addr 5:
  - err_count=1, pass=0, fail_addr=5, fail_data=32'hA5A55A5E.
  - Phase B at addr 5 passes.
- Model returns 0 for all reads, ERR_W=4:
  - err_count saturates at 15, fail_addr=0, fail_data=0, pass=0.
- start pulsed at cycle 10 of an active run:
  - No restart; completion still occurs exactly 96 cycles after the original start.
- clr_n low mid-run during RD_A:
  - All outputs read 0 asynchronously, before the next clock edge.
  - After release, a new start completes normally with pass=1.
- Two back-to-back runs, the first faulty and the second on a fault-free model:
  - The second run clears done/err_count/fail_* on accept and ends with pass=1, err_count=0.
